// File: rtl/sound_arbiter.sv
// Arbitrates the hit/wall/goal collision pulses onto one square-wave audio pin.
// Fixed priority goal > hit > wall, timed tone per event, silent gap between tones.
module sound_arbiter #(
    parameter int unsigned MS_DIV    = 25000,
    parameter int unsigned WALL_HALF = 56818,
    parameter int unsigned HIT_HALF  = 28409,
    parameter int unsigned GOAL_HALF = 12500,
    parameter int unsigned WALL_MS   = 30,
    parameter int unsigned HIT_MS    = 60,
    parameter int unsigned GOAL_MS   = 500,
    parameter int unsigned GAP_MS    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       hit,
    input  logic       wall,
    input  logic       goal,
    output logic       tone,
    output logic       busy,
    output logic [1:0] active_src,
    output logic       dropped
);

    localparam int PRE_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_WALL = 2'd1;
    localparam logic [1:0] SRC_HIT  = 2'd2;
    localparam logic [1:0] SRC_GOAL = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [2:0]       pending, pending_next;
    logic [16:0]      half_cnt, half_next;
    logic [PRE_W-1:0] pre_cnt, pre_next;
    logic [9:0]       ms_cnt, ms_next;
    logic             tone_next;
    logic [1:0]       src_next;
    logic             dropped_next;

    logic [2:0]       events;
    logic [2:0]       clear;
    logic [1:0]       top_src;
    logic [16:0]      cur_half;
    logic [9:0]       cur_dur;
    logic             tick;
    logic             grant;
    logic             preempt;

    assign events = {goal, hit, wall};

    // Source codes double as priority levels, so a plain compare decides preemption.
    always_comb begin
        top_src = SRC_NONE;
        if (pending[2])      top_src = SRC_GOAL;
        else if (pending[1]) top_src = SRC_HIT;
        else if (pending[0]) top_src = SRC_WALL;
    end

    always_comb begin
        cur_half = 17'd1;
        cur_dur  = 10'd1;
        case (active_src)
            SRC_WALL: begin cur_half = 17'(WALL_HALF); cur_dur = 10'(WALL_MS); end
            SRC_HIT:  begin cur_half = 17'(HIT_HALF);  cur_dur = 10'(HIT_MS);  end
            SRC_GOAL: begin cur_half = 17'(GOAL_HALF); cur_dur = 10'(GOAL_MS); end
            default:  begin cur_half = 17'd1;          cur_dur = 10'd1;        end
        endcase
    end

    assign tick = (pre_cnt == PRE_W'(MS_DIV - 1));

    always_comb begin
        state_next   = state;
        pending_next = pending;
        half_next    = half_cnt;
        pre_next     = pre_cnt;
        ms_next      = ms_cnt;
        tone_next    = tone;
        src_next     = active_src;
        dropped_next = 1'b0;
        grant        = 1'b0;
        preempt      = 1'b0;
        clear        = 3'b000;

        if (!enable) begin
            state_next   = IDLE;
            pending_next = 3'b000;
            half_next    = '0;
            pre_next     = '0;
            ms_next      = '0;
            tone_next    = 1'b0;
            src_next     = SRC_NONE;
        end else begin
            case (state)
                IDLE: begin
                    grant = (top_src != SRC_NONE);
                end
                PLAY: begin
                    if (top_src > active_src) begin
                        grant   = 1'b1;
                        preempt = 1'b1;
                    end else begin
                        if (half_cnt == cur_half - 17'd1) begin
                            half_next = '0;
                            tone_next = ~tone;
                        end else begin
                            half_next = half_cnt + 17'd1;
                        end
                        if (tick) begin
                            pre_next = '0;
                            if (ms_cnt == cur_dur - 10'd1) begin
                                state_next = GAP;
                                tone_next  = 1'b0;
                                src_next   = SRC_NONE;
                                ms_next    = '0;
                            end else begin
                                ms_next = ms_cnt + 10'd1;
                            end
                        end else begin
                            pre_next = pre_cnt + PRE_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        pre_next = '0;
                        if (ms_cnt == 10'(GAP_MS - 1)) begin
                            state_next = IDLE;
                            ms_next    = '0;
                        end else begin
                            ms_next = ms_cnt + 10'd1;
                        end
                    end else begin
                        pre_next = pre_cnt + PRE_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase

            if (grant) begin
                state_next = PLAY;
                src_next   = top_src;
                tone_next  = 1'b1;
                half_next  = '0;
                pre_next   = '0;
                ms_next    = '0;
                case (top_src)
                    SRC_WALL: clear = 3'b001;
                    SRC_HIT:  clear = 3'b010;
                    SRC_GOAL: clear = 3'b100;
                    default:  clear = 3'b000;
                endcase
            end

            // A pulse landing on its own grant cycle survives the clear.
            pending_next = (pending & ~clear) | events;
            dropped_next = (|(events & pending & ~clear)) | preempt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= 3'b000;
            half_cnt   <= '0;
            pre_cnt    <= '0;
            ms_cnt     <= '0;
            tone       <= 1'b0;
            busy       <= 1'b0;
            active_src <= SRC_NONE;
            dropped    <= 1'b0;
        end else begin
            state      <= state_next;
            pending    <= pending_next;
            half_cnt   <= half_next;
            pre_cnt    <= pre_next;
            ms_cnt     <= ms_next;
            tone       <= tone_next;
            busy       <= (state_next != IDLE);
            active_src <= src_next;
            dropped    <= dropped_next;
        end
    end

endmodule
